// File: rtl/uart_arb_pkg.sv
// Shared types and default parameters for the UART transmit arbiter.
// Imported by uart_tx_arbiter and rr_picker.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XMIT = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ        = 3;
    localparam int DEF_GAP_CYCLES     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 32768;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, with wrap.
// Reusable by any round-robin arbiter that keeps its own pointer.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [PW-1:0]      winner_o,
    output logic               any_req_o
);

    logic [PW-1:0] idx;

    always_comb begin
        winner_o  = '0;
        any_req_o = 1'b0;
        idx       = ptr_i;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_req_o && req_i[idx]) begin
                any_req_o = 1'b1;
                winner_o  = idx;
            end
            // explicit wrap so non-power-of-two NUM_REQ never indexes past the top
            idx = (idx == PW'(NUM_REQ - 1)) ? '0 : idx + PW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter, one byte per grant, with inter-byte gap.
// Optional XMIT watchdog and tx_err port are built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic                 trmt,
    output logic [7:0]           resp,
    input  logic                 tx_done,
    output logic                 busy
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic                 tx_err
`endif
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    arb_state_t           state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [7:0]           resp_q, resp_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 trmt_q, trmt_d;
    logic                 tx_done_q;

    logic [PW-1:0]        winner;
    logic                 any_req;
    logic [7:0]           win_byte;
    logic                 tx_rise;
    logic                 byte_end;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]          wdog_q, wdog_d;
    logic                 tx_err_q, tx_err_d;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    always_comb begin
        win_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == PW'(i)) win_byte = req_data[8*i +: 8];
        end
    end

    // Only a fresh rising edge completes a byte; a level left over from the previous byte does not.
    assign tx_rise = tx_done & ~tx_done_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        gap_d    = gap_q;
        resp_d   = resp_q;
        gnt_d    = '0;
        done_d   = '0;
        trmt_d   = 1'b0;
        byte_end = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        wdog_d   = wdog_q;
        tx_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    resp_d  = win_byte;
                    owner_d = winner;
                    gnt_d   = NUM_REQ'(1) << winner;
                    trmt_d  = 1'b1;
                    state_d = XMIT;
`ifdef UART_ARB_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end
            end
            XMIT: begin
                if (tx_rise) begin
                    done_d   = NUM_REQ'(1) << owner_q;
                    byte_end = 1'b1;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (wdog_q == WD_LAST) begin
                    tx_err_d = 1'b1;
                    byte_end = 1'b1;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
`endif
                if (byte_end) begin
                    ptr_d   = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
                    gap_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            gap_q     <= '0;
            resp_q    <= 8'h00;
            gnt_q     <= '0;
            done_q    <= '0;
            trmt_q    <= 1'b0;
            tx_done_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            wdog_q    <= '0;
            tx_err_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            gap_q     <= gap_d;
            resp_q    <= resp_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            trmt_q    <= trmt_d;
            tx_done_q <= tx_done;
`ifdef UART_ARB_TIMEOUT_EN
            wdog_q    <= wdog_d;
            tx_err_q  <= tx_err_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign trmt = trmt_q;
    assign resp = resp_q;
    assign busy = (state_q != IDLE);
`ifdef UART_ARB_TIMEOUT_EN
    assign tx_err = tx_err_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with literal latency/order expectations.
module tb_uart_tx_arbiter;

    localparam int N   = 3;
    localparam int GAP = 16;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO    = 100;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 32768;
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic [23:0] req_data = '0;
    logic [2:0]  gnt, done;
    logic        trmt, busy, tx_done;
    logic [7:0]  resp;
    logic        tx_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;
    bit auto_drop = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .trmt     (trmt),
        .resp     (resp),
        .tx_done  (tx_done),
        .busy     (busy)
`ifdef UART_ARB_TIMEOUT_EN
        ,
        .tx_err   (tx_err)
`endif
    );
`ifndef UART_ARB_TIMEOUT_EN
    assign tx_err = 1'b0;
`endif

    // Transmitter stand-in: auto mode clears tx_done on trmt and raises it tx_lat cycles later.
    logic tx_auto = 1'b1;
    logic tx_man = 1'b0;
    logic tx_auto_q = 1'b0;
    int   tx_cnt = 0;
    int   tx_lat = 20;
    assign tx_done = tx_auto ? tx_auto_q : tx_man;

    always @(negedge clk) begin
        if (tx_auto) begin
            if (trmt) begin
                tx_auto_q = 1'b0;
                tx_cnt    = tx_lat;
            end else if (tx_cnt > 0) begin
                tx_cnt = tx_cnt - 1;
                if (tx_cnt == 0) tx_auto_q = 1'b1;
            end
        end
    end

    // Reference model: a byte is in flight until tx_done rises (or the watchdog fires),
    // then GAP idle cycles must pass before any new grant.
    bit         m_in_byte = 1'b0;
    int         m_gap = 0, m_ptr = 0, m_owner = 0, m_wd = 0;
    logic [7:0] m_resp = 8'h00;
    logic       m_last = 1'b0;
    logic [2:0] e_gnt = '0, e_done = '0;
    logic       e_trmt = 1'b0, e_err = 1'b0;
    logic       e_busy;
    assign e_busy = m_in_byte || (m_gap > 0);

    function automatic int pick(input logic [2:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in_byte <= 1'b0; m_gap <= 0; m_ptr <= 0; m_owner <= 0; m_wd <= 0;
            m_resp <= 8'h00; m_last <= 1'b0;
            e_gnt <= '0; e_done <= '0; e_trmt <= 1'b0; e_err <= 1'b0;
        end else begin
            e_gnt <= '0; e_done <= '0; e_trmt <= 1'b0; e_err <= 1'b0;
            m_last <= tx_done;
            if (m_in_byte) begin
                if (tx_done && !m_last) begin
                    e_done    <= 3'(1 << m_owner);
                    m_ptr     <= (m_owner + 1) % N;
                    m_in_byte <= 1'b0;
                    m_gap     <= GAP;
                end else if (TO_EN && m_wd == TO - 1) begin
                    e_err     <= 1'b1;
                    m_ptr     <= (m_owner + 1) % N;
                    m_in_byte <= 1'b0;
                    m_gap     <= GAP;
                end else begin
                    m_wd <= m_wd + 1;
                end
            end else if (m_gap > 0) begin
                m_gap <= m_gap - 1;
            end else if (req != 3'b000) begin
                m_owner   <= pick(req, m_ptr);
                m_resp    <= 8'(req_data >> (8 * pick(req, m_ptr)));
                e_gnt     <= 3'(1 << pick(req, m_ptr));
                e_trmt    <= 1'b1;
                m_in_byte <= 1'b1;
                m_wd      <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && rst_n === 1'b1) begin
            chk("model_gnt",  32'(gnt),    32'(e_gnt));
            chk("model_done", 32'(done),   32'(e_done));
            chk("model_trmt", 32'(trmt),   32'(e_trmt));
            chk("model_resp", 32'(resp),   32'(m_resp));
            chk("model_busy", 32'(busy),   32'(e_busy));
            chk("model_err",  32'(tx_err), 32'(e_err));
        end
    end

    // which: 0=gnt 1=done 2=busy low 3=tx_err
    task automatic wait_on(input string name, input int which, input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if ((which == 0 && gnt != 3'b000) || (which == 1 && done != 3'b000) ||
                (which == 2 && !busy) || (which == 3 && tx_err)) begin
                at = cyc;
                if (which == 0 && auto_drop) req = req & ~gnt;
                break;
            end
        end
        if (at < 0) begin
            chk({"wait_", name}, 32'd0, 32'd1);
            at = cyc;
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    int g, d, b, r, e, c0, nd;
    logic [2:0] og [4];
    logic [7:0] ob [4];

    initial begin
        og = '{3'b001, 3'b010, 3'b100, 3'b001};
        ob = '{8'h11, 8'h22, 8'h33, 8'h11};

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_gnt",  32'(gnt),    32'd0);
        chk("rst_done", 32'(done),   32'd0);
        chk("rst_trmt", 32'(trmt),   32'd0);
        chk("rst_resp", 32'(resp),   32'd0);
        chk("rst_busy", 32'(busy),   32'd0);
        chk("rst_err",  32'(tx_err), 32'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);

        // single request from requester 1
        req_data = {8'h33, 8'hA5, 8'h11};
        req = 3'b010;
        c0 = cyc;
        wait_on("t1_gnt", 0, 10, g);
        chk("t1_gnt_lat", 32'(g - c0), 32'd1);
        chk("t1_gnt", 32'(gnt), 32'b010);
        chk("t1_trmt", 32'(trmt), 32'd1);
        chk("t1_resp", 32'(resp), 32'hA5);
        wait_on("t1_done", 1, 100, d);
        chk("t1_done", 32'(done), 32'b010);
        chk("t1_done_lat", 32'(d - g), 32'd21);
        wait_on("t1_idle", 2, 100, b);
        chk("t1_gap_len", 32'(b - d), 32'd16);

        // async reset mid-byte; pointer (2 here) must return to 0
        tx_man = 1'b1;
        tx_auto = 1'b0;
        req_data = {8'h5A, 8'hA5, 8'h11};
        req = 3'b100;
        wait_on("rst_gnt", 0, 10, g);
        chk("rstm_gnt", 32'(gnt), 32'b100);
        chk("rstm_resp", 32'(resp), 32'h5A);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_gnt",  32'(gnt),    32'd0);
        chk("async_done", 32'(done),   32'd0);
        chk("async_trmt", 32'(trmt),   32'd0);
        chk("async_busy", 32'(busy),   32'd0);
        chk("async_resp", 32'(resp),   32'd0);
        chk("async_err",  32'(tx_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_man = 1'b0;
        repeat (2) @(negedge clk);
        tx_auto = 1'b1;
        req = 3'b110;
        wait_on("post_rst_gnt", 0, 10, g);
        chk("post_rst_gnt", 32'(gnt), 32'b010);
        req = 3'b000;
        wait_on("post_rst_done", 1, 100, d);
        wait_on("post_rst_idle", 2, 100, b);

        // fairness with all requests held
        reset_pulse();
        auto_drop = 1'b0;
        req_data = {8'h33, 8'h22, 8'h11};
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_on("rr_gnt", 0, 100, g);
            chk("rr_order", 32'(gnt), 32'(og[i]));
            chk("rr_resp", 32'(resp), 32'(ob[i]));
            if (i > 0) chk("rr_done_to_gnt", 32'(g - d), 32'd17);
            if (i == 3) req = 3'b000;
            wait_on("rr_done", 1, 100, d);
            chk("rr_done", 32'(done), 32'(og[i]));
        end
        wait_on("rr_idle", 2, 100, b);
        auto_drop = 1'b1;

        // stale tx_done level must not complete the new byte
        reset_pulse();
        tx_man = 1'b1;
        tx_auto = 1'b0;
        repeat (2) @(negedge clk);
        req = 3'b001;
        wait_on("stale_gnt", 0, 10, g);
        chk("stale_gnt", 32'(gnt), 32'b001);
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (done != 3'b000) nd = nd + 1;
        end
        chk("stale_no_done", 32'(nd), 32'd0);
        tx_man = 1'b0;
        repeat (2) @(negedge clk);
        tx_man = 1'b1;
        r = cyc;
        wait_on("stale_done", 1, 10, d);
        chk("stale_done_lat", 32'(d - r), 32'd1);
        chk("stale_done", 32'(done), 32'b001);
        wait_on("stale_idle", 2, 100, b);

        // req[2] with done[0], req[1] during GAP: 1 wins on the updated pointer
        reset_pulse();
        tx_auto = 1'b1;
        req = 3'b001;
        wait_on("sim_gnt0", 0, 10, g);
        chk("sim_gnt0", 32'(gnt), 32'b001);
        wait_on("sim_done0", 1, 100, d);
        req = req | 3'b100;
        chk("sim_done0", 32'(done), 32'b001);
        repeat (5) @(negedge clk);
        req = req | 3'b010;
        wait_on("sim_gnt1", 0, 100, g);
        chk("sim_gnt1", 32'(gnt), 32'b010);
        chk("sim_gap", 32'(g - d), 32'd17);
        wait_on("sim_gnt2", 0, 200, g);
        chk("sim_gnt2", 32'(gnt), 32'b100);
        wait_on("sim_idle", 2, 100, b);

`ifdef UART_ARB_TIMEOUT_EN
        // watchdog abort when tx_done never rises
        reset_pulse();
        tx_man = 1'b0;
        tx_auto = 1'b0;
        req = 3'b001;
        wait_on("to_gnt", 0, 10, g);
        wait_on("to_err", 3, 300, e);
        chk("to_err_lat", 32'(e - g), 32'd100);
        chk("to_no_done", 32'(done), 32'd0);
        wait_on("to_idle", 2, 100, b);
        chk("to_gap_len", 32'(b - e), 32'd16);
        tx_auto = 1'b1;
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
